// File: rtl/ex_mem_wb_pipe_pkg.sv
// Shared definitions for the EX->MEM->WB pipeline: register ids, memory FSM states, stage bundles.
// Optional DMEM_TIMEOUT_EN (see dmem_access_fsm) bounds the data-memory wait.
package ex_mem_wb_pipe_pkg;

  localparam logic [4:0] rR0 = 5'd0;
  localparam logic [4:0] rF  = 5'd1;
  localparam logic [4:0] rA  = 5'd2;
  localparam logic [4:0] rB  = 5'd3;
  localparam logic [4:0] rC  = 5'd4;
  localparam logic [4:0] rD  = 5'd5;
  localparam logic [4:0] rE  = 5'd6;
  localparam logic [4:0] rBC = 5'd7;
  localparam logic [4:0] rDE = 5'd8;
  localparam logic [4:0] rHL = 5'd9;
  localparam logic [4:0] rT0 = 5'd10;
  localparam logic [4:0] rT1 = 5'd11;
  localparam logic [4:0] rT2 = 5'd12;
  localparam logic [4:0] rT3 = 5'd13;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1,
    M_DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [15:0] result;
    logic [4:0]  wr_id;
    logic [7:0]  flags;
    logic [7:0]  fmask;
    logic        is_load;
    logic        is_store;
    logic [7:0]  st_data;
  } mem_bundle_t;

  typedef struct packed {
    logic [15:0] result;
    logic [4:0]  wr_id;
    logic [7:0]  flags;
    logic [7:0]  fmask;
  } wb_bundle_t;

  localparam mem_bundle_t MEM_BUBBLE = '{result: 16'h0000, wr_id: rR0, flags: 8'h00,
                                         fmask: 8'h00, is_load: 1'b0, is_store: 1'b0,
                                         st_data: 8'h00};
  localparam wb_bundle_t  WB_BUBBLE  = '{result: 16'h0000, wr_id: rR0, flags: 8'h00,
                                         fmask: 8'h00};

endpackage

// File: rtl/ex_mem_wb_pipe_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the memory (slave).
interface ex_mem_wb_pipe_if;
  logic        Dmem_req;
  logic        Dmem_we;
  logic [15:0] Dmem_addr;
  logic [7:0]  Dmem_wdata;
  logic        Dmem_ack;
  logic [7:0]  Dmem_rdata;

  modport master (
    output Dmem_req, Dmem_we, Dmem_addr, Dmem_wdata,
    input  Dmem_ack, Dmem_rdata
  );

  modport slave (
    input  Dmem_req, Dmem_we, Dmem_addr, Dmem_wdata,
    output Dmem_ack, Dmem_rdata
  );
endinterface

// File: rtl/ex_mem_wb_pipe_dmem_access_fsm.sv
// MEM-stage data-memory sequencer: request/ack FSM, stall generation, load-capture strobes.
// DMEM_TIMEOUT_EN adds a wait-cycle counter that abandons an unacknowledged access and pulses mem_err.
module dmem_access_fsm
  import ex_mem_wb_pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_op,
  input  logic ack,
  output logic req,
  output logic stall,
  output logic ack_take,
  output logic timeout_fire,
  output logic mem_err
);

  mem_state_t state_reg, state_next;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= M_IDLE;
    else     state_reg <= state_next;
  end

`ifdef DMEM_TIMEOUT_EN
  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT_CYCLES - 1);
  logic [3:0] cnt_reg, cnt_next;
  logic       err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= 4'd0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      err_reg <= timeout_fire;
    end
  end

  assign mem_err = err_reg;
`else
  assign mem_err = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    req          = 1'b0;
    ack_take     = 1'b0;
    timeout_fire = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    cnt_next     = cnt_reg;
`endif
    case (state_reg)
      M_IDLE: begin
        if (mem_op) begin
          req = 1'b1;
          if (ack) begin
            ack_take   = 1'b1;
            state_next = M_DONE;
          end else begin
            state_next = M_WAIT;
`ifdef DMEM_TIMEOUT_EN
            cnt_next   = 4'd0;
`endif
          end
        end
      end
      M_WAIT: begin
        req = mem_op;
        if (ack) begin
          ack_take   = mem_op;
          state_next = M_DONE;
        end
`ifdef DMEM_TIMEOUT_EN
        // The counter holds the number of wait cycles already spent without an ack.
        else if (cnt_reg == CNT_LAST) begin
          timeout_fire = mem_op;
          state_next   = M_DONE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
`endif
      end
      M_DONE:  state_next = M_IDLE;
      default: state_next = M_IDLE;
    endcase
  end

  // Stall covers the ack cycle too; M_DONE is the single cycle the pipeline moves.
  assign stall = mem_op && (state_reg != M_DONE);

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX->MEM->WB pipeline registers with a req/ack data-memory access in MEM.
// Build option DMEM_TIMEOUT_EN bounds the memory wait to TIMEOUT_CYCLES wait cycles.
module ex_mem_wb_pipe
  import ex_mem_wb_pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_valid,
  input  logic [15:0] EX_Result,
  input  logic [4:0]  EX_Wr_id,
  input  logic [7:0]  EX_Flags,
  input  logic [7:0]  EX_Fmask,
  input  logic        EX_is_load,
  input  logic        EX_is_store,
  input  logic [7:0]  EX_St_data,
  input  logic        Flush,
  output logic        Pipe_stall,
  ex_mem_wb_pipe_if.master dmem,
  output logic [15:0] MEM_Result,
  output logic [4:0]  MEM_Wr_id,
  output logic [7:0]  MEM_Flags,
  output logic [7:0]  MEM_Fmask,
  output logic [15:0] WB_Result,
  output logic [4:0]  WB_Wr_id,
  output logic [7:0]  WB_Flags,
  output logic [7:0]  WB_Fmask,
  output logic        RF_Wr_en,
  output logic        Mem_err
);

  mem_bundle_t mem_reg, mem_next;
  wb_bundle_t  wb_reg, wb_next;
  logic        mem_op;
  logic        stall;
  logic        req;
  logic        ack_take;
  logic        timeout_fire;

  assign mem_op = mem_reg.is_load | mem_reg.is_store;

  dmem_access_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_dmem_access_fsm (
    .clk          (clk),
    .rst          (rst),
    .mem_op       (mem_op),
    .ack          (dmem.Dmem_ack),
    .req          (req),
    .stall        (stall),
    .ack_take     (ack_take),
    .timeout_fire (timeout_fire),
    .mem_err      (Mem_err)
  );

  always_comb begin
    mem_next = mem_reg;
    if (!stall) begin
      if (EX_valid && !Flush) begin
        mem_next.result   = EX_Result;
        mem_next.wr_id    = EX_Wr_id;
        mem_next.flags    = EX_Flags;
        mem_next.fmask    = EX_Fmask;
        mem_next.is_load  = EX_is_load;
        mem_next.is_store = EX_is_store;
        mem_next.st_data  = EX_St_data;
        // Stores never write the register file or the flags.
        if (EX_is_store) begin
          mem_next.wr_id = rR0;
          mem_next.fmask = 8'h00;
        end
      end else begin
        mem_next = MEM_BUBBLE;
      end
    end else if (mem_reg.is_load && ack_take) begin
      mem_next.result = {8'h00, dmem.Dmem_rdata};
    end else if (mem_reg.is_load && timeout_fire) begin
      mem_next.result = 16'hFFFF;
    end
  end

  // A bubble enters WB on every stall cycle so a held instruction is written only once.
  always_comb begin
    wb_next = WB_BUBBLE;
    if (!stall) begin
      wb_next.result = mem_reg.result;
      wb_next.wr_id  = mem_reg.wr_id;
      wb_next.flags  = mem_reg.flags;
      wb_next.fmask  = mem_reg.fmask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_reg <= MEM_BUBBLE;
      wb_reg  <= WB_BUBBLE;
    end else begin
      mem_reg <= mem_next;
      wb_reg  <= wb_next;
    end
  end

  assign Pipe_stall      = stall;
  assign dmem.Dmem_req   = req;
  assign dmem.Dmem_we    = mem_reg.is_store;
  assign dmem.Dmem_addr  = mem_reg.result;
  assign dmem.Dmem_wdata = mem_reg.st_data;

  assign MEM_Result = mem_reg.result;
  assign MEM_Wr_id  = mem_reg.wr_id;
  assign MEM_Flags  = mem_reg.flags;
  assign MEM_Fmask  = mem_reg.fmask;
  assign WB_Result  = wb_reg.result;
  assign WB_Wr_id   = wb_reg.wr_id;
  assign WB_Flags   = wb_reg.flags;
  assign WB_Fmask   = wb_reg.fmask;
  assign RF_Wr_en   = (wb_reg.wr_id != rR0);

endmodule
